scalar_scoreboard_ctrl: RTL and testbench
=========================================

# scalar_scoreboard_ctrl

Scoreboard controller for the scalar back end of the tensor core. It sits between dispatch and the three scalar function units: ALU, LD_ST and BRANCH. It keeps the scalar FU status table (one row per FU) and a register result-status table. It enforces structural, RAW, WAW and WAR hazards, issues operands to FUs, and arbitrates the single scalar register-file writeback port.

## Interface
- NUM_FU, 3, scalar FUs; index = fu_scalar encoding (ALU=0, LD_ST=1, BRANCH=2)
- NUM_REG, 32, scalar architectural registers; x0 never tracked
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- disp_valid  in  1  dispatch offers an instruction
- disp_ready  out  1  controller accepts it this cycle
- disp_fu  in  FU_S_W  target FU
- disp_wen  in  1  instruction writes disp_rd
- disp_rd, disp_rs1, disp_rs2  in  REG_W each  register specifiers
- issue_valid  out  NUM_FU  per-FU: operands ready, read register file
- issue_ready  in  NUM_FU  per-FU: FU takes operands
- wb_req  in  NUM_FU  per-FU: result ready to write
- wb_grant  out  NUM_FU  one-hot-or-zero writeback grant
- flush  in  1  synchronous squash of all in-flight state
- fust  out  NUM_FU x fust_s_row_t  table snapshot for debug/perf

## Operation
- Per-row state: busy, issued, r, r1, r2, t1, t2.
  - t1 and t2 are fu_tag_t = {valid, FU index}.
  - A set valid means the operand is still pending on that FU.
- Result status rstat[NUM_REG]: fu_tag_t per register. rstat[0] is always invalid.
- Dispatch accept: disp_ready = !busy[disp_fu] && !(disp_wen && disp_rd!=0 && rstat[disp_rd].valid).
  - Both conditions are evaluated on registered state.
  - disp_ready does not depend on disp_valid.
- On accept (disp_valid && disp_ready):
  - Row disp_fu gets busy=1, issued=0, r=disp_wen?disp_rd:0, r1, r2.
  - t1 = rstat[rs1] and t2 = rstat[rs2]. A tag is forced invalid if its rs is 0, or if its producer is granted writeback in the same cycle (bypass).
  - rstat[disp_rd] = {1, disp_fu} when disp_wen && rd != 0.
- Issue: issue_valid[i] = busy && !issued && !t1.valid && !t2.valid. On issue_valid[i] && issue_ready[i], issued is set.
- Writeback eligibility for row i requires all of:
  - busy && issued && wb_req[i];
  - no WAR hazard: no row j != i with busy_j && !issued_j and either (r1_j==r_i, r_i!=0, !t1_j.valid) or (r2_j==r_i, r_i!=0, !t2_j.valid).
- Arbiter:
  - Round-robin among eligible rows; at most one grant per cycle.
  - The pointer advances to (granted index + 1) mod NUM_FU; it holds when nothing is granted.
  - Pointer reset value is 0 (ALU highest priority first).
- On grant i:
  - busy[i] and issued[i] clear.
  - If r_i != 0, rstat[r_i] is invalidated.
  - Every t1/t2 tagged {1,i} in any row is invalidated.
- wb_req without busy && issued is ignored; the FU must hold wb_req until granted.
- flush: all busy, issued, t and rstat clear and the RR pointer goes to 0. An accept, issue or grant in the same cycle as flush is discarded.
- Reset (nRST low, any time including mid-operation): same state as flush, asynchronously.
  - Outputs during reset: disp_ready=1, issue_valid=0, wb_grant=0, fust all zero.

## Timing
- disp_ready, issue_valid and wb_grant are combinational from registered state plus current inputs. There is no combinational path from issue_ready to any output.
- Latency:
  - An accepted instruction with ready operands raises issue_valid the next cycle.
  - A grant at cycle N frees the FU row and rstat entry, so the same FU accepts a new dispatch at cycle N+1.
  - A consumer waiting on the granted tag raises issue_valid at N+1.
- A same-cycle grant and dispatch to the same FU is not accepted; busy is evaluated pre-grant.
- A same-cycle grant of rd and a dispatch with WAW on that rd is stalled one cycle.
- A same-cycle grant of rs and a dispatch reading rs is accepted with its tag cleared (bypass).

## Structure
- Additions to the shared types package:
  - fu_tag_t (valid + fu_sbits_t);
  - fust_s_row_t extended with an issued bit and t1/t2 retyped to fu_tag_t;
  - fust_s_t sized [NUM_FU-1:0];
  - localparam NUM_SCALAR_FU = 3.
- One sub-module: rr_arbiter (parameterised width N, inputs req and advance, outputs grant), reusable for the later matrix scoreboard.

## Test plan
- Independent ops: ALU rd=5 and LD_ST rd=6 dispatched in consecutive cycles, both wb_req held -> both issue the cycle after accept; grants ALU then LD_ST on consecutive cycles.
- RAW: LD_ST rd=3, then ALU rs1=3 -> ALU t1={1,1}, issue_valid[0] stays 0 until the LD_ST grant at N, then rises at N+1.
- WAW: ALU rd=7 in flight, BRANCH wen rd=7 offered -> disp_ready=0 until the ALU grant, accepted the cycle after.
- WAR: LD_ST reads rs2=9 with issue_ready held low, ALU writes rd=9 and raises wb_req -> no ALU grant until the LD_ST issues; granted the following cycle.
- Round-robin: all three FUs request writeback continuously from pointer 0 -> grants ALU, LD_ST, BRANCH; rd=0 writebacks leave rstat untouched.
- Flush/reset: three rows busy, flush pulse (then nRST low mid-cycle in a second run) -> all busy 0, disp_ready=1, issue_valid=0, wb_grant=0 immediately (reset) or next cycle (flush).

Source files
------------

// File: rtl/scalar_scoreboard_ctrl_pkg.sv
// Shared types for the scalar scoreboard: FU encoding, operand tags and
// the FU status table rows exported for debug/perf.
package scalar_scoreboard_ctrl_pkg;

   localparam int NUM_SCALAR_FU = 3;
   localparam int NUM_FU        = NUM_SCALAR_FU;
   localparam int NUM_REG       = 32;
   localparam int FU_S_W        = 2;
   localparam int REG_W         = 5;

   typedef logic [FU_S_W-1:0] fu_sbits_t;
   typedef logic [REG_W-1:0]  reg_idx_t;

   typedef enum fu_sbits_t {
      FU_ALU    = 2'd0,
      FU_LD_ST  = 2'd1,
      FU_BRANCH = 2'd2
   } fu_scalar_t;

   // valid set: value still pending on FU 'fu'
   typedef struct packed {
      logic      valid;
      fu_sbits_t fu;
   } fu_tag_t;

   typedef struct packed {
      logic     busy;
      logic     issued;
      reg_idx_t r;
      reg_idx_t r1;
      reg_idx_t r2;
      fu_tag_t  t1;
      fu_tag_t  t2;
   } fust_s_row_t;

   typedef fust_s_row_t [NUM_FU-1:0] fust_s_t;

   // Source tag captured at dispatch: x0 never waits, and a producer being
   // written back this very cycle is already satisfied.
   function automatic fu_tag_t src_tag(fu_tag_t prod, reg_idx_t rs,
                                       logic gnt_any, fu_sbits_t gnt_fu);
      fu_tag_t t;
      t = prod;
      if (rs == '0 || (gnt_any && prod.fu == gnt_fu))
         t = '0;
      return t;
   endfunction

endpackage

// File: rtl/scalar_scoreboard_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the winner when 'advance' is set.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         advance,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_next;
   logic             found;

   // scan requesters in rotated order starting at the pointer
   always_comb begin
      grant    = '0;
      ptr_next = ptr;
      found    = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && req[i] && i == ((int'(ptr) + k) % N)) begin
               grant[i] = 1'b1;
               found    = 1'b1;
               ptr_next = PTR_W'((i + 1) % N);
            end
         end
      end
   end

   // pointer register; holds when nothing is granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (clear)
         ptr <= '0;
      else if (advance && found)
         ptr <= ptr_next;
   end

endmodule

// File: rtl/scalar_scoreboard_ctrl.sv
// Scalar scoreboard: FU status table plus register result status. Gates
// dispatch on structural/WAW hazards, issue on RAW, writeback on WAR, and
// arbitrates the single register-file write port.
module scalar_scoreboard_ctrl
   import scalar_scoreboard_ctrl_pkg::*;
(
   input  logic              CLK,
   input  logic              nRST,
   input  logic              disp_valid,
   output logic              disp_ready,
   input  fu_sbits_t         disp_fu,
   input  logic              disp_wen,
   input  reg_idx_t          disp_rd,
   input  reg_idx_t          disp_rs1,
   input  reg_idx_t          disp_rs2,
   output logic [NUM_FU-1:0] issue_valid,
   input  logic [NUM_FU-1:0] issue_ready,
   input  logic [NUM_FU-1:0] wb_req,
   output logic [NUM_FU-1:0] wb_grant,
   input  logic              flush,
   output fust_s_t           fust
);

   fust_s_t           fust_q, fust_d;
   fu_tag_t           rstat_q [NUM_REG];
   fu_tag_t           rstat_d [NUM_REG];
   logic [NUM_FU-1:0] war;
   logic [NUM_FU-1:0] elig;
   logic [NUM_FU-1:0] grant_raw;
   logic              gnt_any;
   fu_sbits_t         gnt_idx;
   logic              fu_ok;
   logic              accept;
   fust_s_row_t       new_row;

   assign fust = fust_q;

   // dispatch gating uses pre-grant state only
   always_comb begin
      fu_ok      = disp_fu < FU_S_W'(NUM_FU);
      disp_ready = fu_ok && !fust_q[disp_fu].busy &&
                   !(disp_wen && disp_rd != '0 && rstat_q[disp_rd].valid);
      accept     = disp_valid && disp_ready && !flush;
   end

   // issue readiness, WAR blocking and writeback eligibility per row
   always_comb begin
      issue_valid = '0;
      war         = '0;
      elig        = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         issue_valid[i] = fust_q[i].busy && !fust_q[i].issued &&
                          !fust_q[i].t1.valid && !fust_q[i].t2.valid;
         for (int j = 0; j < NUM_FU; j++) begin
            if (j != i && fust_q[j].busy && !fust_q[j].issued && fust_q[i].r != '0) begin
               if ((fust_q[j].r1 == fust_q[i].r && !fust_q[j].t1.valid) ||
                   (fust_q[j].r2 == fust_q[i].r && !fust_q[j].t2.valid))
                  war[i] = 1'b1;
            end
         end
         elig[i] = fust_q[i].busy && fust_q[i].issued && wb_req[i] && !war[i];
      end
   end

   rr_arbiter #(.N(NUM_FU)) u_wb_arb (
      .clk     (CLK),
      .rst_n   (nRST),
      .clear   (flush),
      .advance (1'b1),
      .req     (elig),
      .grant   (grant_raw)
   );

   // a flush squashes the grant so no FU retires a discarded result
   always_comb begin
      wb_grant = flush ? '0 : grant_raw;
      gnt_any  = |wb_grant;
      gnt_idx  = '0;
      for (int i = 0; i < NUM_FU; i++)
         if (wb_grant[i]) gnt_idx = FU_S_W'(i);
   end

   // next table state: retire the granted row, mark issues, then accept
   always_comb begin
      fust_d  = fust_q;
      rstat_d = rstat_q;
      new_row = '0;
      if (gnt_any) begin
         fust_d[gnt_idx].busy   = 1'b0;
         fust_d[gnt_idx].issued = 1'b0;
         if (fust_q[gnt_idx].r != '0)
            rstat_d[fust_q[gnt_idx].r] = '0;
         for (int i = 0; i < NUM_FU; i++) begin
            if (fust_q[i].t1.valid && fust_q[i].t1.fu == gnt_idx) fust_d[i].t1 = '0;
            if (fust_q[i].t2.valid && fust_q[i].t2.fu == gnt_idx) fust_d[i].t2 = '0;
         end
      end
      for (int i = 0; i < NUM_FU; i++)
         if (issue_valid[i] && issue_ready[i]) fust_d[i].issued = 1'b1;
      if (accept) begin
         new_row.busy = 1'b1;
         new_row.r    = disp_wen ? disp_rd : '0;
         new_row.r1   = disp_rs1;
         new_row.r2   = disp_rs2;
         new_row.t1   = src_tag(rstat_q[disp_rs1], disp_rs1, gnt_any, gnt_idx);
         new_row.t2   = src_tag(rstat_q[disp_rs2], disp_rs2, gnt_any, gnt_idx);
         fust_d[disp_fu] = new_row;
         if (disp_wen && disp_rd != '0)
            rstat_d[disp_rd] = '{valid: 1'b1, fu: disp_fu};
      end
   end

   // table registers; flush and reset both return to the empty table
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fust_q <= '0;
         for (int k = 0; k < NUM_REG; k++) rstat_q[k] <= '0;
      end else if (flush) begin
         fust_q <= '0;
         for (int k = 0; k < NUM_REG; k++) rstat_q[k] <= '0;
      end else begin
         fust_q  <= fust_d;
         rstat_q <= rstat_d;
      end
   end

endmodule

// File: tb/tb_scalar_scoreboard_ctrl.sv
// Bench for scalar_scoreboard_ctrl: directed hazard scenarios followed by
// random traffic, all checked each cycle against an instruction-level model.
module tb_scalar_scoreboard_ctrl;
   import scalar_scoreboard_ctrl_pkg::*;

   logic              CLK = 1'b0;
   logic              nRST = 1'b1;
   logic              disp_valid = 1'b0;
   logic              disp_ready;
   fu_sbits_t         disp_fu = '0;
   logic              disp_wen = 1'b0;
   reg_idx_t          disp_rd = '0, disp_rs1 = '0, disp_rs2 = '0;
   logic [NUM_FU-1:0] issue_valid;
   logic [NUM_FU-1:0] issue_ready = '0;
   logic [NUM_FU-1:0] wb_req = '0;
   logic [NUM_FU-1:0] wb_grant;
   logic              flush = 1'b0;
   fust_s_t           fust;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   scalar_scoreboard_ctrl dut (
      .CLK(CLK), .nRST(nRST),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu),
      .disp_wen(disp_wen), .disp_rd(disp_rd), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .wb_req(wb_req), .wb_grant(wb_grant), .flush(flush), .fust(fust)
   );

   // Model: each FU holds at most one instruction identified by a unique id;
   // operands remember the id of their producer and wait while it is alive.
   int m_id  [NUM_FU];
   bit m_iss [NUM_FU];
   int m_rd  [NUM_FU];
   int m_rs1 [NUM_FU];
   int m_rs2 [NUM_FU];
   int m_p1  [NUM_FU];
   int m_p2  [NUM_FU];
   int m_writer [NUM_REG];
   int m_next;
   int m_ptr;

   logic              exp_ready;
   logic [NUM_FU-1:0] exp_issue, exp_grant;
   int                exp_gi;
   logic              obs_ready;
   logic [NUM_FU-1:0] obs_issue, obs_grant;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_FU; i++) begin
         m_id[i] = 0; m_iss[i] = 0; m_rd[i] = 0; m_rs1[i] = 0;
         m_rs2[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
      end
      for (int r = 0; r < NUM_REG; r++) m_writer[r] = 0;
      m_ptr = 0;
      if (m_next == 0) m_next = 1;
   endtask

   function automatic bit live(int id);
      if (id == 0) return 1'b0;
      for (int i = 0; i < NUM_FU; i++) if (m_id[i] == id) return 1'b1;
      return 1'b0;
   endfunction

   // a writer must wait while any unissued reader still needs the old value
   function automatic bit war_blocked(int i);
      if (m_rd[i] == 0) return 1'b0;
      for (int j = 0; j < NUM_FU; j++) begin
         if (j != i && m_id[j] != 0 && !m_iss[j]) begin
            if (m_rs1[j] == m_rd[i] && !live(m_p1[j])) return 1'b1;
            if (m_rs2[j] == m_rd[i] && !live(m_p2[j])) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   task automatic model_eval();
      int idx;
      exp_ready = (m_id[int'(disp_fu)] == 0) &&
                  !(disp_wen && disp_rd != 0 && m_writer[int'(disp_rd)] != 0);
      exp_issue = '0;
      exp_grant = '0;
      exp_gi    = -1;
      for (int i = 0; i < NUM_FU; i++)
         exp_issue[i] = m_id[i] != 0 && !m_iss[i] && !live(m_p1[i]) && !live(m_p2[i]);
      for (int k = 0; k < NUM_FU; k++) begin
         idx = (m_ptr + k) % NUM_FU;
         if (exp_gi < 0 && m_id[idx] != 0 && m_iss[idx] && wb_req[idx] && !war_blocked(idx))
            exp_gi = idx;
      end
      if (flush) exp_gi = -1;
      if (exp_gi >= 0) exp_grant[exp_gi] = 1'b1;
   endtask

   task automatic model_commit();
      int f;
      if (flush) begin
         model_reset();
         return;
      end
      if (exp_gi >= 0) begin
         if (m_rd[exp_gi] != 0) m_writer[m_rd[exp_gi]] = 0;
         m_id[exp_gi]  = 0;
         m_iss[exp_gi] = 0;
         m_ptr = (exp_gi + 1) % NUM_FU;
      end
      for (int i = 0; i < NUM_FU; i++)
         if (exp_issue[i] && issue_ready[i]) m_iss[i] = 1;
      if (disp_valid && exp_ready) begin
         f = int'(disp_fu);
         m_id[f]  = m_next;
         m_iss[f] = 0;
         m_rd[f]  = disp_wen ? int'(disp_rd) : 0;
         m_rs1[f] = int'(disp_rs1);
         m_rs2[f] = int'(disp_rs2);
         m_p1[f]  = (disp_rs1 != 0) ? m_writer[int'(disp_rs1)] : 0;
         m_p2[f]  = (disp_rs2 != 0) ? m_writer[int'(disp_rs2)] : 0;
         if (m_rd[f] != 0) m_writer[m_rd[f]] = m_next;
         m_next++;
      end
   endtask

   // one clock: compare at the falling edge, advance the model at the rising edge
   task automatic cycle();
      @(negedge CLK);
      model_eval();
      obs_ready = disp_ready;
      obs_issue = issue_valid;
      obs_grant = wb_grant;
      check("disp_ready", 128'(disp_ready), 128'(exp_ready));
      check("issue_valid", 128'(issue_valid), 128'(exp_issue));
      check("wb_grant", 128'(wb_grant), 128'(exp_grant));
      for (int i = 0; i < NUM_FU; i++) begin
         check($sformatf("busy[%0d]", i), 128'(fust[i].busy), 128'(m_id[i] != 0));
         check($sformatf("issued[%0d]", i), 128'(fust[i].issued), 128'(m_id[i] != 0 && m_iss[i]));
      end
      @(posedge CLK);
      model_commit();
      #1;
   endtask

   task automatic offer(input int fu, input bit wen, input int rd, input int rs1, input int rs2);
      disp_valid = 1'b1;
      disp_fu    = fu_sbits_t'(fu);
      disp_wen   = wen;
      disp_rd    = reg_idx_t'(rd);
      disp_rs1   = reg_idx_t'(rs1);
      disp_rs2   = reg_idx_t'(rs2);
   endtask

   task automatic idle();
      disp_valid = 1'b0;
   endtask

   task automatic apply_reset();
      disp_valid = 0; disp_fu = '0; disp_wen = 0; disp_rd = '0; disp_rs1 = '0; disp_rs2 = '0;
      flush = 0; issue_ready = '0; wb_req = '0;
      nRST = 1'b0;
      #1;
      model_reset();
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      m_next = 0;
      #1;
      apply_reset();
      check("reset disp_ready", 128'(disp_ready), 128'(1));
      check("reset issue_valid", 128'(issue_valid), 128'(0));
      check("reset fust", 128'(fust), 128'(0));

      // independent ops: ALU then LD_ST, grants on consecutive cycles
      issue_ready = 3'b111; wb_req = 3'b111;
      offer(FU_ALU, 1, 5, 0, 0);   cycle();
      offer(FU_LD_ST, 1, 6, 0, 0); cycle();
      check("indep alu issue", 128'(obs_issue), 128'(3'b001));
      idle(); cycle();
      check("indep grant alu", 128'(obs_grant), 128'(3'b001));
      cycle();
      check("indep grant ldst", 128'(obs_grant), 128'(3'b010));

      // RAW: ALU waits on LD_ST x3
      apply_reset();
      issue_ready = 3'b111;
      offer(FU_LD_ST, 1, 3, 0, 0); cycle();
      offer(FU_ALU, 1, 4, 3, 0);   cycle();
      check("raw t1 tag", 128'(fust[0].t1), 128'(3'b101));
      idle(); wb_req = 3'b010; cycle();
      check("raw grant ldst", 128'(obs_grant), 128'(3'b010));
      check("raw alu waiting", 128'(obs_issue[0]), 128'(0));
      wb_req = 3'b000; cycle();
      check("raw alu issues", 128'(obs_issue[0]), 128'(1));

      // WAW: BRANCH x7 held off until the ALU x7 writes back
      apply_reset();
      issue_ready = 3'b111;
      offer(FU_ALU, 1, 7, 0, 0);    cycle();
      offer(FU_BRANCH, 1, 7, 0, 0); cycle();
      check("waw stall 1", 128'(obs_ready), 128'(0));
      wb_req = 3'b001; cycle();
      check("waw stall at grant", 128'(obs_ready), 128'(0));
      check("waw grant alu", 128'(obs_grant), 128'(3'b001));
      cycle();
      check("waw accept", 128'(obs_ready), 128'(1));
      idle(); wb_req = 3'b111; repeat (4) cycle();

      // WAR: ALU x9 write blocked until the LD_ST reader of x9 issues
      apply_reset();
      offer(FU_LD_ST, 1, 10, 0, 9); cycle();
      issue_ready = 3'b001;
      offer(FU_ALU, 1, 9, 0, 0);    cycle();
      idle(); wb_req = 3'b001;      cycle();
      cycle();
      check("war blocked 1", 128'(obs_grant), 128'(0));
      cycle();
      check("war blocked 2", 128'(obs_grant), 128'(0));
      issue_ready = 3'b011;         cycle();
      check("war still blocked", 128'(obs_grant), 128'(0));
      cycle();
      check("war granted", 128'(obs_grant), 128'(3'b001));

      // round robin across all three FUs, rd=0 writeback keeps x12 pending
      apply_reset();
      issue_ready = 3'b111;
      offer(FU_ALU, 1, 0, 0, 0);    cycle();
      offer(FU_LD_ST, 1, 12, 0, 0); cycle();
      offer(FU_BRANCH, 0, 0, 0, 0); cycle();
      idle(); cycle();
      wb_req = 3'b111; cycle();
      check("rr grant alu", 128'(obs_grant), 128'(3'b001));
      offer(FU_ALU, 1, 12, 0, 0); cycle();
      check("rr grant ldst", 128'(obs_grant), 128'(3'b010));
      check("rr x12 still pending", 128'(obs_ready), 128'(0));
      cycle();
      check("rr grant branch", 128'(obs_grant), 128'(3'b100));
      check("rr x12 free", 128'(obs_ready), 128'(1));
      idle(); repeat (4) cycle();

      // flush with three busy rows
      apply_reset();
      offer(FU_ALU, 1, 1, 0, 0);    cycle();
      offer(FU_LD_ST, 1, 2, 0, 0);  cycle();
      offer(FU_BRANCH, 1, 3, 0, 0); cycle();
      check("flush pre busy", 128'({fust[2].busy, fust[1].busy, fust[0].busy}), 128'(3'b111));
      offer(FU_ALU, 1, 4, 0, 0); flush = 1'b1; cycle();
      flush = 1'b0; idle(); disp_fu = fu_sbits_t'(FU_ALU); cycle();
      check("flush disp_ready", 128'(obs_ready), 128'(1));
      check("flush issue_valid", 128'(obs_issue), 128'(0));
      check("flush grant", 128'(obs_grant), 128'(0));
      check("flush fust", 128'(fust), 128'(0));

      // asynchronous reset in the middle of a cycle
      offer(FU_ALU, 1, 1, 0, 0);    cycle();
      offer(FU_LD_ST, 1, 2, 0, 0);  cycle();
      offer(FU_BRANCH, 1, 3, 0, 0); wb_req = 3'b111; cycle();
      idle(); disp_fu = fu_sbits_t'(FU_ALU);
      #2 nRST = 1'b0;
      #1;
      check("mid reset disp_ready", 128'(disp_ready), 128'(1));
      check("mid reset issue_valid", 128'(issue_valid), 128'(0));
      check("mid reset grant", 128'(wb_grant), 128'(0));
      check("mid reset fust", 128'(fust), 128'(0));
      model_reset();
      @(posedge CLK);
      #1 nRST = 1'b1;

      // random traffic over a small register window to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         disp_valid  = ($urandom_range(0, 3) != 0);
         disp_fu     = fu_sbits_t'($urandom_range(0, 2));
         disp_wen    = ($urandom_range(0, 3) != 0);
         disp_rd     = reg_idx_t'($urandom_range(0, 7));
         disp_rs1    = reg_idx_t'($urandom_range(0, 7));
         disp_rs2    = reg_idx_t'($urandom_range(0, 7));
         issue_ready = 3'($urandom_range(0, 7));
         wb_req      = 3'($urandom_range(0, 7));
         flush       = ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
